// File: rtl/out_port_uart_tx_if.sv
// rtl/out_port_uart_tx_if.sv - handshake bundle between the output register and the UART serialiser
interface out_port_uart_tx_if;
    logic [31:0] data_in;
    logic        start;
    logic        tx;
    logic        busy;
    logic        done;
    logic        overrun;

    modport master (output data_in, start, input tx, busy, done, overrun);
    modport slave  (input data_in, start, output tx, busy, done, overrun);
endinterface

// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - sends a captured 32-bit word as four back-to-back 8N1 UART frames
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT   = 434,
    parameter bit MSB_BYTE_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    out_port_uart_tx_if.slave         bus
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [31:0]   r_shift;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [BW-1:0] r_baud;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    logic          r_overrun;
    logic [31:0]   w_capture;
    logic          w_bit_end;

    // Bytes are reordered at capture so the shifter always drains from bit 0.
    assign w_capture = MSB_BYTE_FIRST ?
        {bus.data_in[7:0], bus.data_in[15:8], bus.data_in[23:16], bus.data_in[31:24]} :
        bus.data_in;
    assign w_bit_end = (r_baud == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= 32'd0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_shift <= w_capture;
                        r_byte  <= 2'd0;
                        r_bit   <= 3'd0;
                        r_baud  <= '0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[31:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_byte != 2'd3) begin
                            r_byte  <= r_byte + 2'd1;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.tx      = r_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb/tb_out_port_uart_tx.sv - directed bench for out_port_uart_tx in both byte orders
module tb_out_port_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int MID   = CPB / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_r [2];
    logic [31:0] data_r  [2];

    out_port_uart_tx_if if0 ();
    out_port_uart_tx_if if1 ();

    assign if0.start   = start_r[0];
    assign if0.data_in = data_r[0];
    assign if1.start   = start_r[1];
    assign if1.data_in = data_r[1];

    out_port_uart_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .bus(if0.slave));
    out_port_uart_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .bus(if1.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic h_tx   [0:399];
    logic h_busy [0:399];
    logic h_done [0:399];
    logic h_ovr  [0:399];

    typedef struct {
        int          sel;
        logic [31:0] word;
        logic [31:0] exp_seq;
        string       nm;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int sel, input int n, input int inj_c, input logic [31:0] inj_d);
        for (int c = 1; c <= n; c++) begin
            tick();
            h_tx[c]   = sel ? if1.tx      : if0.tx;
            h_busy[c] = sel ? if1.busy    : if0.busy;
            h_done[c] = sel ? if1.done    : if0.done;
            h_ovr[c]  = sel ? if1.overrun : if0.overrun;
            start_r[sel] = (c == inj_c);
            if (c == inj_c)
                data_r[sel] = inj_d;
            else if (c == 1)
                data_r[sel] = ~data_r[sel];
        end
        start_r[sel] = 1'b0;
    endtask

    task automatic launch(input int sel, input logic [31:0] w);
        data_r[sel]  = w;
        start_r[sel] = 1'b1;
    endtask

    task automatic check_frames(input int base, input logic [31:0] exp_seq, input string nm);
        logic [7:0] by;
        logic [7:0] exp_b;
        int b0;
        for (int f = 0; f < 4; f++) begin
            b0 = base + f * FRAME;
            for (int k = 0; k < 8; k++) by[k] = h_tx[b0 + (k + 1) * CPB + MID];
            exp_b = exp_seq[31 - 8*f -: 8];
            check($sformatf("%s frame%0d byte", nm, f), {24'd0, by}, {24'd0, exp_b});
            check($sformatf("%s frame%0d start/stop", nm, f),
                  {30'd0, h_tx[b0 + MID], h_tx[b0 + 9*CPB + MID]}, 32'd1);
        end
    endtask

    task automatic check_single_timing(input string nm);
        int nb;
        int nd;
        nb = 0;
        nd = 0;
        for (int c = 1; c <= 170; c++) begin
            nb += int'(h_busy[c]);
            nd += int'(h_done[c]);
        end
        check({nm, " busy cycles"}, nb, 160);
        check({nm, " busy window"}, {29'd0, h_busy[1], h_busy[160], h_busy[161]}, 32'b110);
        check({nm, " done count"}, nd, 1);
        check({nm, " done at 161"}, {31'd0, h_done[161]}, 32'd1);
    endtask

    initial begin
        int nb;
        int nd;
        int ntx;
        vecs[0] = '{0, 32'h12345678, 32'h78563412, "lsb 12345678"};
        vecs[1] = '{1, 32'h12345678, 32'h12345678, "msb 12345678"};
        vecs[2] = '{0, 32'h0F00A5C3, 32'hC3A5000F, "lsb 0F00A5C3"};
        vecs[3] = '{1, 32'h0F00A5C3, 32'h0F00A5C3, "msb 0F00A5C3"};

        start_r[0] = 1'b0; start_r[1] = 1'b0;
        data_r[0]  = 32'd0; data_r[1]  = 32'd0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset lsb outputs", {28'd0, if0.tx, if0.busy, if0.done, if0.overrun}, 32'b1000);
        check("reset msb outputs", {28'd0, if1.tx, if1.busy, if1.done, if1.overrun}, 32'b1000);
        tick();

        for (int i = 0; i < 4; i++) begin
            launch(vecs[i].sel, vecs[i].word);
            capture(vecs[i].sel, 170, -1, 32'd0);
            check({vecs[i].nm, " first tx low"}, {31'd0, h_tx[1]}, 32'd0);
            check_frames(1, vecs[i].exp_seq, vecs[i].nm);
            check_single_timing(vecs[i].nm);
            repeat (3) tick();
        end

        nb = 0; nd = 0; ntx = 0;
        for (int c = 0; c < 200; c++) begin
            data_r[0] = $urandom;
            tick();
            ntx += int'(!if0.tx);
            nb  += int'(if0.busy);
            nd  += int'(if0.done);
        end
        check("idle tx low count", ntx, 0);
        check("idle busy count", nb, 0);
        check("idle done count", nd, 0);

        launch(0, 32'hA5A5A5A5);
        capture(0, 170, 50, 32'hFFFFFFFF);
        check_frames(1, 32'hA5A5A5A5, "overrun");
        check("overrun before second start", {31'd0, h_ovr[50]}, 32'd0);
        check("overrun at 51", {31'd0, h_ovr[51]}, 32'd1);
        check("overrun after done", {31'd0, h_ovr[170]}, 32'd1);
        check("overrun done at 161", {31'd0, h_done[161]}, 32'd1);
        tick();

        launch(0, 32'h000000FF);
        capture(0, 330, 161, 32'h00000001);
        nd = 0;
        for (int c = 1; c <= 330; c++) nd += int'(h_done[c]);
        check("b2b done count", nd, 2);
        check("b2b done cycles", {30'd0, h_done[161], h_done[322]}, 32'b11);
        check("b2b second start bit", {30'd0, h_tx[162], h_busy[162]}, 32'b01);
        check_frames(1, 32'hFF000000, "b2b word1");
        check_frames(162, 32'h01000000, "b2b word2");
        tick();

        launch(0, 32'h12345678);
        for (int c = 1; c <= 55; c++) begin
            tick();
            start_r[0] = 1'b0;
        end
        reset = 1'b1;
        tick();
        check("mid reset outputs", {28'd0, if0.tx, if0.busy, if0.done, if0.overrun}, 32'b1000);
        start_r[0] = 1'b1;
        data_r[0]  = 32'hCAFEF00D;
        tick();
        check("reset beats start", {30'd0, if0.tx, if0.busy}, 32'b10);
        reset = 1'b0;
        start_r[0] = 1'b0;
        repeat (2) tick();
        check("post reset idle", {30'd0, if0.tx, if0.busy}, 32'b10);
        launch(0, 32'hDEADBEEF);
        capture(0, 170, -1, 32'd0);
        check_frames(1, 32'hEFBEADDE, "after reset");
        check_single_timing("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
